win_line_scanner: RTL and testbench
===================================

Name: win_line_scanner

Overview:
- Parametrised successor to the hard-coded Connect-4 win checker.
- Walks every start cell and direction of a ROWS x COLS board held in the board RAM and reads WIN_LEN cells per valid window through a pipelined RAM port with configurable read latency.
- Reports the first winner found, a draw, or no result.
- Sits between the game FSM (start/done handshake) and the board RAM read port; the game FSM owns address muxing.

Parameters:
- ROWS, 6, board rows; row 0 is the top row.
- COLS, 7, board columns.
- WIN_LEN, 4, run length needed to win; must satisfy 2 <= WIN_LEN <= min(ROWS,COLS).
- ADDR_W, 6, RAM address width.
- BASE_ADDR, 7, RAM address of cell (row 0, col 0); cell address = BASE_ADDR + row*COLS + col.
- RD_LAT, 2, RAM read latency in cycles, >= 1.

Ports:
- clk  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- start  in  1  one-cycle request to scan; ignored while busy
- clear  in  1  synchronous abort; returns to IDLE and clears results
- rd_addr  out  ADDR_W  board RAM read address
- rd_data  in  2  RAM data: 00 empty, 01 player 1, 10 player 2, 11 treated as empty
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle pulse when the scan ends
- result  out  2  00 none, 01 P1 win, 10 P2 win, 11 draw; held until next start/clear
- win_addr  out  ADDR_W  address of the winning window's first cell; 0 if none
- win_dir  out  2  0 horiz (+col), 1 vert (+row), 2 diag (+row,+col), 3 anti-diag (+row,-col)
- dbg_window  out  8  see Optional Feature

Behaviour:
- Reset (async, resetn=0): state IDLE; rd_addr=BASE_ADDR, busy=0, done=0, result=00, win_addr=0, win_dir=0, dbg_window=0.
- States: IDLE, SETUP, ISSUE, WAIT, EVAL, DONE.
- IDLE: on start=1, clear result/win_*; set row=col=dir=0 and zero_seen=0; go to SETUP.
- SETUP (1 cycle per (cell,dir) pair):
  - Checks that the window fits on the board.
  - If it does not fit: advance dir 0..3, then col, then row (row-major), and stay in SETUP.
  - If it fits: go to ISSUE. If the last pair is exhausted, go to DONE.
- ISSUE (WIN_LEN cycles): cycle k drives rd_addr = address of window cell k.
- Data for issue k is valid on rd_data exactly RD_LAT cycles later and is captured into slot k.
- WAIT (RD_LAT cycles): captures the remaining in-flight data; rd_addr holds its last value.
- EVAL (1 cycle):
  - Every captured value equal to 00 or 11 sets zero_seen.
  - If all WIN_LEN slots are equal and are 01 or 10: latch result, win_addr, win_dir and go to DONE immediately (first window in scan order wins).
  - Otherwise advance and go to SETUP.
- DONE: done=1 for 1 cycle.
  - If no win was latched: result=11 if zero_seen=0, else 00.
  - busy=0 from the next cycle; return to IDLE.
- Defaults: 168 SETUP cycles plus 69 valid windows x 7 cycles gives a 651-cycle no-win scan; done is high in cycle 652 after start is sampled.
- Draw detection is valid because horizontal windows cover every cell (WIN_LEN <= COLS).
- Anti-diagonal windows start at col >= WIN_LEN-1.
- clear=1 in any state: next state IDLE, result/win_* cleared, done=0. No RAM side effects (read-only block). clear takes priority over start in the same cycle.
- start while busy: ignored; does not restart the scan.
- Row/col/index arithmetic uses widths from $clog2 of ROWS, COLS, WIN_LEN.
- Address add wraps modulo 2^ADDR_W (the integrator sizes ADDR_W).

Optional Feature:
- Macro: WIN_SCAN_DEBUG_EN.
- When defined: dbg_window counts valid windows evaluated since start (saturates at 255) and freezes at done, for display on HEX digits.
- When undefined: dbg_window is tied to 0 and the counter logic is removed.

Test Plan:
- Empty board (all 00), defaults, start -> done in cycle 652, result=00, win_addr=0, busy low after done.
- P1 at addresses 7,8,9,10 (row 0, cols 0-3) -> result=01, win_addr=7, win_dir=0, done after the first valid window (cycle 9).
- P2 at 0x0E,0x15,0x1C,0x23 (col 0, rows 1-4) -> result=10, win_addr=0x0E, win_dir=1.
- P1 at 0x0A,0x10,0x16,0x1C (anti-diagonal) -> result=01, win_addr=0x0A, win_dir=3.
- Full board, alternating pattern with no 4-run -> result=11 at cycle 652.
- clear pulsed at scan cycle 100, then a second start -> result=00 and done absent after the clear; the rescan completes normally.
- Separately, resetn=0 mid-scan clears all outputs asynchronously.

Source files
------------

// File: rtl/win_line_scanner.sv
// win_line_scanner: walks every (cell, direction) pair of a ROWS x COLS board
// held in a read-only board RAM, fetches WIN_LEN cells per window that fits on
// the board through a RAM port with RD_LAT cycles of read latency, and reports
// the first winning window in row-major / direction order, a draw, or nothing.
// Optional build macro WIN_SCAN_DEBUG_EN: dbg_window counts evaluated windows
// (saturating at 255, frozen at done); without it dbg_window is tied to zero.
module win_line_scanner #(
  parameter int ROWS      = 6,
  parameter int COLS      = 7,
  parameter int WIN_LEN   = 4,
  parameter int ADDR_W    = 6,
  parameter int BASE_ADDR = 7,
  parameter int RD_LAT    = 2
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  input  logic              clear,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [1:0]        rd_data,
  output logic              busy,
  output logic              done,
  output logic [1:0]        result,
  output logic [ADDR_W-1:0] win_addr,
  output logic [1:0]        win_dir,
  output logic [7:0]        dbg_window
);

  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int IW = (WIN_LEN > 1) ? $clog2(WIN_LEN) : 1;
  localparam int LW = $clog2(RD_LAT + 1);

  localparam logic [RW-1:0]     ROW_LAST     = RW'(ROWS - 1);
  localparam logic [RW-1:0]     ROW_FIT_MAX  = RW'(ROWS - WIN_LEN);
  localparam logic [CW-1:0]     COL_LAST     = CW'(COLS - 1);
  localparam logic [CW-1:0]     COL_FIT_MAX  = CW'(COLS - WIN_LEN);
  localparam logic [CW-1:0]     COL_ANTI_MIN = CW'(WIN_LEN - 1);
  localparam logic [IW-1:0]     IDX_LAST     = IW'(WIN_LEN - 1);
  localparam logic [LW-1:0]     WAIT_LAST    = LW'(RD_LAT - 1);
  localparam logic [ADDR_W-1:0] STEP_H       = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] STEP_V       = ADDR_W'(COLS);
  localparam logic [ADDR_W-1:0] STEP_D       = ADDR_W'(COLS + 1);
  localparam logic [ADDR_W-1:0] STEP_A       = ADDR_W'(COLS - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_ISSUE = 3'd2,
    S_WAIT  = 3'd3,
    S_EVAL  = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t            r_state;
  state_t            w_next_state;

  logic [RW-1:0]     r_row;
  logic [CW-1:0]     r_col;
  logic [1:0]        r_dir;
  logic [IW-1:0]     r_idx;
  logic [LW-1:0]     r_wait_cnt;
  logic              r_zero_seen;
  logic [ADDR_W-1:0] r_win_base;
  logic [ADDR_W-1:0] r_rd_addr;
  logic              r_busy;
  logic              r_done;
  logic [1:0]        r_result;
  logic [ADDR_W-1:0] r_win_addr;
  logic [1:0]        r_win_dir;
  logic [1:0]        r_slot [WIN_LEN];
  logic              r_pipe_vld [RD_LAT];
  logic [IW-1:0]     r_pipe_idx [RD_LAT];

  logic              w_fits;
  logic              w_last_pair;
  logic [RW-1:0]     w_row_nxt;
  logic [CW-1:0]     w_col_nxt;
  logic [1:0]        w_dir_nxt;
  logic [ADDR_W-1:0] w_cell_addr;
  logic [ADDR_W-1:0] w_step;
  logic              w_any_empty;
  logic              w_all_equal;
  logic              w_win;
  logic              w_zero_seen_nxt;

  // Board address of a cell; the sum wraps modulo 2^ADDR_W.
  function automatic logic [ADDR_W-1:0] cell_addr(input logic [RW-1:0] row,
                                                  input logic [CW-1:0] col);
    cell_addr = ADDR_W'(BASE_ADDR) + ADDR_W'(row) * ADDR_W'(COLS) + ADDR_W'(col);
  endfunction

  assign w_cell_addr = cell_addr(r_row, r_col);
  assign w_last_pair = (r_row == ROW_LAST) && (r_col == COL_LAST) && (r_dir == 2'd3);

  // Does the window starting at (row, col) in direction dir stay on the board?
  always_comb begin
    w_fits = 1'b0;
    case (r_dir)
      2'd0:    w_fits = (r_col <= COL_FIT_MAX);
      2'd1:    w_fits = (r_row <= ROW_FIT_MAX);
      2'd2:    w_fits = (r_row <= ROW_FIT_MAX) && (r_col <= COL_FIT_MAX);
      2'd3:    w_fits = (r_row <= ROW_FIT_MAX) && (r_col >= COL_ANTI_MIN);
      default: w_fits = 1'b0;
    endcase
  end

  // Address increment between consecutive cells of a window.
  always_comb begin
    w_step = STEP_H;
    case (r_dir)
      2'd0:    w_step = STEP_H;
      2'd1:    w_step = STEP_V;
      2'd2:    w_step = STEP_D;
      2'd3:    w_step = STEP_A;
      default: w_step = STEP_H;
    endcase
  end

  // Next (cell, dir) pair: direction fastest, then column, then row.
  always_comb begin
    w_dir_nxt = r_dir + 2'd1;
    w_col_nxt = r_col;
    w_row_nxt = r_row;
    if (r_dir == 2'd3) begin
      if (r_col == COL_LAST) begin
        w_col_nxt = {CW{1'b0}};
        w_row_nxt = r_row + RW'(1);
      end else begin
        w_col_nxt = r_col + CW'(1);
        w_row_nxt = r_row;
      end
    end else begin
      w_col_nxt = r_col;
      w_row_nxt = r_row;
    end
  end

  // Window evaluation: a win needs all slots equal and holding a player code.
  always_comb begin
    w_any_empty = 1'b0;
    w_all_equal = 1'b1;
    for (int k = 0; k < WIN_LEN; k++) begin
      w_any_empty = w_any_empty | (r_slot[k] == 2'b00) | (r_slot[k] == 2'b11);
      w_all_equal = w_all_equal & (r_slot[k] == r_slot[0]);
    end
    w_win           = w_all_equal & ~w_any_empty;
    w_zero_seen_nxt = r_zero_seen | w_any_empty;
  end

  // Next-state logic; clear overrides everything, including start.
  always_comb begin
    w_next_state = r_state;
    if (clear) begin
      w_next_state = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  w_next_state = start ? S_SETUP : S_IDLE;
        S_SETUP: begin
          if (w_fits)           w_next_state = S_ISSUE;
          else if (w_last_pair) w_next_state = S_DONE;
          else                  w_next_state = S_SETUP;
        end
        S_ISSUE: w_next_state = (r_idx == IDX_LAST) ? S_WAIT : S_ISSUE;
        S_WAIT:  w_next_state = (r_wait_cnt == WAIT_LAST) ? S_EVAL : S_WAIT;
        S_EVAL: begin
          if (w_win || w_last_pair) w_next_state = S_DONE;
          else                      w_next_state = S_SETUP;
        end
        S_DONE:  w_next_state = S_IDLE;
        default: w_next_state = S_IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= S_IDLE;
    else         r_state <= w_next_state;
  end

  // Scan position, window sequencing and draw tracking.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_row       <= {RW{1'b0}};
      r_col       <= {CW{1'b0}};
      r_dir       <= 2'd0;
      r_idx       <= {IW{1'b0}};
      r_wait_cnt  <= {LW{1'b0}};
      r_zero_seen <= 1'b0;
      r_win_base  <= {ADDR_W{1'b0}};
    end else if (clear) begin
      r_row       <= {RW{1'b0}};
      r_col       <= {CW{1'b0}};
      r_dir       <= 2'd0;
      r_idx       <= {IW{1'b0}};
      r_wait_cnt  <= {LW{1'b0}};
      r_zero_seen <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_row       <= {RW{1'b0}};
            r_col       <= {CW{1'b0}};
            r_dir       <= 2'd0;
            r_zero_seen <= 1'b0;
          end
        end
        S_SETUP: begin
          r_idx      <= {IW{1'b0}};
          r_win_base <= w_cell_addr;
          if (!w_fits && !w_last_pair) begin
            r_row <= w_row_nxt;
            r_col <= w_col_nxt;
            r_dir <= w_dir_nxt;
          end
        end
        S_ISSUE: begin
          r_wait_cnt <= {LW{1'b0}};
          if (r_idx != IDX_LAST) r_idx <= r_idx + IW'(1);
        end
        S_WAIT: r_wait_cnt <= r_wait_cnt + LW'(1);
        S_EVAL: begin
          r_zero_seen <= w_zero_seen_nxt;
          if (!w_win && !w_last_pair) begin
            r_row <= w_row_nxt;
            r_col <= w_col_nxt;
            r_dir <= w_dir_nxt;
          end
        end
        default: ;
      endcase
    end
  end

  // Read address: first cell loaded in SETUP, stepped once per ISSUE cycle, held otherwise.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_rd_addr <= ADDR_W'(BASE_ADDR);
    end else if (!clear && (r_state == S_SETUP) && w_fits) begin
      r_rd_addr <= w_cell_addr;
    end else if (!clear && (r_state == S_ISSUE) && (r_idx != IDX_LAST)) begin
      r_rd_addr <= r_rd_addr + w_step;
    end
  end

  // Tag each issued read with its slot index and capture the data RD_LAT cycles later.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < RD_LAT; i++) begin
        r_pipe_vld[i] <= 1'b0;
        r_pipe_idx[i] <= {IW{1'b0}};
      end
      for (int k = 0; k < WIN_LEN; k++) r_slot[k] <= 2'b00;
    end else if (clear) begin
      for (int i = 0; i < RD_LAT; i++) r_pipe_vld[i] <= 1'b0;
    end else begin
      r_pipe_vld[0] <= (r_state == S_ISSUE);
      r_pipe_idx[0] <= r_idx;
      for (int i = 1; i < RD_LAT; i++) begin
        r_pipe_vld[i] <= r_pipe_vld[i-1];
        r_pipe_idx[i] <= r_pipe_idx[i-1];
      end
      if (r_pipe_vld[RD_LAT-1]) r_slot[r_pipe_idx[RD_LAT-1]] <= rd_data;
    end
  end

  // Handshake and result registers; the result is valid in the same cycle as done.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_result   <= 2'b00;
      r_win_addr <= {ADDR_W{1'b0}};
      r_win_dir  <= 2'd0;
    end else begin
      r_busy <= (w_next_state != S_IDLE);
      r_done <= (w_next_state == S_DONE);
      if (clear) begin
        r_result   <= 2'b00;
        r_win_addr <= {ADDR_W{1'b0}};
        r_win_dir  <= 2'd0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (start) begin
              r_result   <= 2'b00;
              r_win_addr <= {ADDR_W{1'b0}};
              r_win_dir  <= 2'd0;
            end
          end
          S_SETUP: begin
            if (!w_fits && w_last_pair) r_result <= r_zero_seen ? 2'b00 : 2'b11;
          end
          S_EVAL: begin
            if (w_win) begin
              r_result   <= r_slot[0];
              r_win_addr <= r_win_base;
              r_win_dir  <= r_dir;
            end else if (w_last_pair) begin
              r_result <= w_zero_seen_nxt ? 2'b00 : 2'b11;
            end
          end
          default: ;
        endcase
      end
    end
  end

`ifdef WIN_SCAN_DEBUG_EN
  logic [7:0] r_dbg_cnt;

  // Count evaluated windows since start; saturates, and freezes once the scan ends.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_dbg_cnt <= 8'd0;
    end else if (clear) begin
      r_dbg_cnt <= 8'd0;
    end else if ((r_state == S_IDLE) && start) begin
      r_dbg_cnt <= 8'd0;
    end else if ((r_state == S_EVAL) && (r_dbg_cnt != 8'hFF)) begin
      r_dbg_cnt <= r_dbg_cnt + 8'd1;
    end
  end

  assign dbg_window = r_dbg_cnt;
`else
  assign dbg_window = 8'd0;
`endif

  assign rd_addr  = r_rd_addr;
  assign busy     = r_busy;
  assign done     = r_done;
  assign result   = r_result;
  assign win_addr = r_win_addr;
  assign win_dir  = r_win_dir;

endmodule

// File: tb/tb_win_line_scanner.sv
// Directed bench for win_line_scanner with default parameters. A behavioural
// board RAM returns data two cycles after the address is presented.
module tb_win_line_scanner;

`ifdef WIN_SCAN_DEBUG_EN
  localparam bit DBG_ON = 1'b1;
`else
  localparam bit DBG_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       start = 1'b0;
  logic       clear = 1'b0;
  logic [5:0] rd_addr;
  logic [1:0] rd_data;
  logic       busy;
  logic       done;
  logic [1:0] result;
  logic [5:0] win_addr;
  logic [1:0] win_dir;
  logic [7:0] dbg_window;

  logic [1:0] mem [64];
  logic [1:0] rd_d1;
  logic [1:0] rd_d2;

  int n_cmp = 0;
  int n_err = 0;

  win_line_scanner dut (
    .clk(clk), .resetn(resetn), .start(start), .clear(clear),
    .rd_addr(rd_addr), .rd_data(rd_data), .busy(busy), .done(done),
    .result(result), .win_addr(win_addr), .win_dir(win_dir),
    .dbg_window(dbg_window)
  );

  always #5 clk = ~clk;

  // Two-cycle read latency board RAM.
  always @(posedge clk) begin
    rd_d1 <= mem[rd_addr];
    rd_d2 <= rd_d1;
  end
  assign rd_data = rd_d2;

  task automatic fill_board(input logic [1:0] v);
    for (int a = 0; a < 64; a++) mem[a] = v;
  endtask

  // Pulse start; return the cycle index (1 = first cycle after start is sampled)
  // in which done is seen, or max_cyc on timeout. start is re-pulsed at restart_at.
  task automatic run_scan(input int max_cyc, input int restart_at,
                          output int cyc, output logic busy1);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    cyc = 1;
    busy1 = busy;
    while (done !== 1'b1 && cyc < max_cyc) begin
      start = (cyc == restart_at);
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    fill_board(2'b00);
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if (rd_addr !== 6'd7) begin n_err++; $display("FAIL reset_rd_addr got %0d want 7", rd_addr); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done got %b want 0", done); end
    n_cmp++; if (result !== 2'b00) begin n_err++; $display("FAIL reset_result got %b want 00", result); end
    n_cmp++; if (win_addr !== 6'd0) begin n_err++; $display("FAIL reset_win_addr got %0d want 0", win_addr); end
    n_cmp++; if (win_dir !== 2'd0) begin n_err++; $display("FAIL reset_win_dir got %0d want 0", win_dir); end
    n_cmp++; if (dbg_window !== 8'd0) begin n_err++; $display("FAIL reset_dbg got %0d want 0", dbg_window); end
    resetn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_empty();
    int cyc;
    logic b1;
    fill_board(2'b00);
    run_scan(2000, -1, cyc, b1);
    n_cmp++; if (cyc !== 652 || done !== 1'b1) begin n_err++; $display("FAIL empty_done_cycle got %0d want 652", cyc); end
    n_cmp++; if (b1 !== 1'b1) begin n_err++; $display("FAIL empty_busy_c1 got %b want 1", b1); end
    n_cmp++; if (result !== 2'b00) begin n_err++; $display("FAIL empty_result got %b want 00", result); end
    n_cmp++; if (win_addr !== 6'd0) begin n_err++; $display("FAIL empty_win_addr got %0d want 0", win_addr); end
    n_cmp++; if (dbg_window !== (DBG_ON ? 8'd69 : 8'd0)) begin n_err++; $display("FAIL empty_dbg got %0d want %0d", dbg_window, DBG_ON ? 69 : 0); end
    @(negedge clk);
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL empty_done_pulse got %b want 0", done); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL empty_busy_after got %b want 0", busy); end
  endtask

  // Row 0 horizontal P1 win; a start during the scan must be ignored.
  task automatic test_horiz();
    int cyc;
    logic b1;
    fill_board(2'b00);
    for (int a = 7; a <= 10; a++) mem[a] = 2'b01;
    run_scan(2000, 5, cyc, b1);
    n_cmp++; if (cyc !== 9 || done !== 1'b1) begin n_err++; $display("FAIL horiz_done_cycle got %0d want 9", cyc); end
    n_cmp++; if (result !== 2'b01) begin n_err++; $display("FAIL horiz_result got %b want 01", result); end
    n_cmp++; if (win_addr !== 6'd7) begin n_err++; $display("FAIL horiz_win_addr got %0d want 7", win_addr); end
    n_cmp++; if (win_dir !== 2'd0) begin n_err++; $display("FAIL horiz_win_dir got %0d want 0", win_dir); end
    n_cmp++; if (dbg_window !== (DBG_ON ? 8'd1 : 8'd0)) begin n_err++; $display("FAIL horiz_dbg got %0d want %0d", dbg_window, DBG_ON ? 1 : 0); end
    repeat (3) @(negedge clk);
    n_cmp++; if (busy !== 1'b0 || result !== 2'b01) begin n_err++; $display("FAIL horiz_held got busy=%b result=%b want busy=0 result=01", busy, result); end
    clear = 1'b1;
    @(negedge clk); clear = 1'b0;
    n_cmp++; if (result !== 2'b00 || win_addr !== 6'd0) begin n_err++; $display("FAIL idle_clear got result=%b win_addr=%0d want 00/0", result, win_addr); end
  endtask

  task automatic test_vert();
    int cyc;
    logic b1;
    fill_board(2'b00);
    mem[14] = 2'b10; mem[21] = 2'b10; mem[28] = 2'b10; mem[35] = 2'b10;
    run_scan(2000, -1, cyc, b1);
    n_cmp++; if (cyc !== 178 || done !== 1'b1) begin n_err++; $display("FAIL vert_done_cycle got %0d want 178", cyc); end
    n_cmp++; if (result !== 2'b10) begin n_err++; $display("FAIL vert_result got %b want 10", result); end
    n_cmp++; if (win_addr !== 6'h0E) begin n_err++; $display("FAIL vert_win_addr got %0d want 14", win_addr); end
    n_cmp++; if (win_dir !== 2'd1) begin n_err++; $display("FAIL vert_win_dir got %0d want 1", win_dir); end
    n_cmp++; if (dbg_window !== (DBG_ON ? 8'd21 : 8'd0)) begin n_err++; $display("FAIL vert_dbg got %0d want %0d", dbg_window, DBG_ON ? 21 : 0); end
  endtask

  task automatic test_anti();
    int cyc;
    logic b1;
    fill_board(2'b00);
    mem[10] = 2'b01; mem[16] = 2'b01; mem[22] = 2'b01; mem[28] = 2'b01;
    run_scan(2000, 50, cyc, b1);
    n_cmp++; if (cyc !== 108 || done !== 1'b1) begin n_err++; $display("FAIL anti_done_cycle got %0d want 108", cyc); end
    n_cmp++; if (result !== 2'b01) begin n_err++; $display("FAIL anti_result got %b want 01", result); end
    n_cmp++; if (win_addr !== 6'h0A) begin n_err++; $display("FAIL anti_win_addr got %0d want 10", win_addr); end
    n_cmp++; if (win_dir !== 2'd3) begin n_err++; $display("FAIL anti_win_dir got %0d want 3", win_dir); end
    n_cmp++; if (dbg_window !== (DBG_ON ? 8'd13 : 8'd0)) begin n_err++; $display("FAIL anti_dbg got %0d want %0d", dbg_window, DBG_ON ? 13 : 0); end
  endtask

  // Full board with runs of at most two in every direction, then a board of 11 codes.
  task automatic test_draw();
    int cyc;
    logic b1;
    fill_board(2'b00);
    for (int r = 0; r < 6; r++)
      for (int c = 0; c < 7; c++)
        mem[7 + r*7 + c] = ((((c >> 1) + r) % 2) == 0) ? 2'b01 : 2'b10;
    run_scan(2000, -1, cyc, b1);
    n_cmp++; if (cyc !== 652 || done !== 1'b1) begin n_err++; $display("FAIL draw_done_cycle got %0d want 652", cyc); end
    n_cmp++; if (result !== 2'b11) begin n_err++; $display("FAIL draw_result got %b want 11", result); end
    n_cmp++; if (win_addr !== 6'd0) begin n_err++; $display("FAIL draw_win_addr got %0d want 0", win_addr); end
    fill_board(2'b11);
    run_scan(2000, -1, cyc, b1);
    n_cmp++; if (cyc !== 652 || done !== 1'b1) begin n_err++; $display("FAIL code11_done_cycle got %0d want 652", cyc); end
    n_cmp++; if (result !== 2'b00) begin n_err++; $display("FAIL code11_result got %b want 00", result); end
  endtask

  task automatic test_clear();
    int cyc;
    int seen;
    logic b1;
    fill_board(2'b00);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (99) @(negedge clk);
    clear = 1'b1;
    @(negedge clk); clear = 1'b0;
    n_cmp++; if (busy !== 1'b0 || done !== 1'b0 || result !== 2'b00) begin n_err++; $display("FAIL clear_mid got busy=%b done=%b result=%b want 0/0/00", busy, done, result); end
    seen = 0;
    for (int i = 0; i < 700; i++) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) seen++;
    end
    n_cmp++; if (seen !== 0) begin n_err++; $display("FAIL clear_quiet got %0d active cycles want 0", seen); end
    clear = 1'b1; start = 1'b1;
    @(negedge clk); clear = 1'b0; start = 1'b0;
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL clear_beats_start got busy=%b want 0", busy); end
    run_scan(2000, -1, cyc, b1);
    n_cmp++; if (cyc !== 652 || done !== 1'b1) begin n_err++; $display("FAIL rescan_done_cycle got %0d want 652", cyc); end
    n_cmp++; if (result !== 2'b00) begin n_err++; $display("FAIL rescan_result got %b want 00", result); end
  endtask

  task automatic test_async_reset();
    int cyc;
    logic b1;
    fill_board(2'b00);
    for (int a = 7; a <= 10; a++) mem[a] = 2'b01;
    run_scan(2000, -1, cyc, b1);
    n_cmp++; if (rd_addr !== 6'd10 || done !== 1'b1) begin n_err++; $display("FAIL areset_pre got rd_addr=%0d done=%b want 10/1", rd_addr, done); end
    resetn = 1'b0;
    #1;
    n_cmp++; if (busy !== 1'b0 || done !== 1'b0) begin n_err++; $display("FAIL areset_hs got busy=%b done=%b want 0/0", busy, done); end
    n_cmp++; if (result !== 2'b00 || win_addr !== 6'd0 || win_dir !== 2'd0) begin n_err++; $display("FAIL areset_res got %b/%0d/%0d want 00/0/0", result, win_addr, win_dir); end
    n_cmp++; if (rd_addr !== 6'd7 || dbg_window !== 8'd0) begin n_err++; $display("FAIL areset_addr got rd_addr=%0d dbg=%0d want 7/0", rd_addr, dbg_window); end
    @(negedge clk); resetn = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_empty();
    test_horiz();
    test_vert();
    test_anti();
    test_draw();
    test_clear();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
